trap_sequencer: RTL and testbench

//  Machine-mode trap controller for the single CSR-file write port. Prioritises simultaneous

---
 rtl/trap_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_trap_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// ---------------------------------------------------------------------------
// trap_sequencer
//   Machine-mode trap controller that owns the single CSR-file write port
//   while a trap or mret is being taken. It picks the highest-priority
//   request, writes mepc/mcause/mtval/mstatus in order (or only mstatus for
//   mret), holds the pipeline flushed, then issues a single PC redirect.
//   When idle, pipeline CSR writes pass straight through to the CSR file.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   interrupt                       external interrupt request (level)
//   illegal_inst, ecall_m           synchronous exception sources
//   l_access_fault, s_access_fault  data access faults
//   mret                            mret retiring
//   epc_cur / epc_next              faulting PC / interrupt return PC
//   bad_addr                        faulting data address
//   inst_csr_we/addr/wdata          pipeline CSR write request
//   mstatus_in, mtvec_in, mepc_in   current CSR values
//   csr_we/waddr/wdata              CSR file write port
//   inst_csr_stall                  pipeline CSR write blocked
//   flush_all                       flush the whole pipeline
//   redirect_valid / redirect_pc    one-cycle PC redirect
//   busy                            sequence in progress
// ---------------------------------------------------------------------------
module trap_sequencer #(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              interrupt,
    input  logic              illegal_inst,
    input  logic              ecall_m,
    input  logic              l_access_fault,
    input  logic              s_access_fault,
    input  logic              mret,
    input  logic [XLEN-1:0]   epc_cur,
    input  logic [XLEN-1:0]   epc_next,
    input  logic [XLEN-1:0]   bad_addr,
    input  logic              inst_csr_we,
    input  logic [CSR_AW-1:0] inst_csr_addr,
    input  logic [XLEN-1:0]   inst_csr_wdata,
    input  logic [XLEN-1:0]   mstatus_in,
    input  logic [XLEN-1:0]   mtvec_in,
    input  logic [XLEN-1:0]   mepc_in,
    output logic              csr_we,
    output logic [CSR_AW-1:0] csr_waddr,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              inst_csr_stall,
    output logic              flush_all,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_MEPC,
        S_W_MCAUSE,
        S_W_MTVAL,
        S_W_MSTATUS,
        S_M_MSTATUS,
        S_REDIRECT
    } state_t;

    localparam logic [CSR_AW-1:0] A_MSTATUS = CSR_AW'(12'h300);
    localparam logic [CSR_AW-1:0] A_MEPC    = CSR_AW'(12'h341);
    localparam logic [CSR_AW-1:0] A_MCAUSE  = CSR_AW'(12'h342);
    localparam logic [CSR_AW-1:0] A_MTVAL   = CSR_AW'(12'h343);

    // Interrupt bit set, exception code 11 (machine external interrupt).
    localparam logic [XLEN-1:0] CAUSE_MEI = {1'b1, {(XLEN-5){1'b0}}, 4'hB};

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_epc;
    logic [XLEN-1:0] r_tval;
    logic            r_is_mret;

    logic            w_int_event;
    logic            w_event;
    logic [XLEN-1:0] w_cause;
    logic [XLEN-1:0] w_epc;
    logic [XLEN-1:0] w_tval;
    logic            w_is_mret;
    logic [XLEN-1:0] w_mstatus_trap;
    logic [XLEN-1:0] w_mstatus_mret;

    // Low mtvec bits hold the vector mode; the redirect always uses direct mode.
    logic            w_unused_ok;
    assign w_unused_ok = &{1'b0, mtvec_in[1:0]};

    // A masked interrupt is not an event at all.
    assign w_int_event = interrupt & mstatus_in[3];
    assign w_event     = w_int_event | illegal_inst | ecall_m |
                         l_access_fault | s_access_fault | mret;

    // Priority select of the trap fields to latch.
    always_comb begin
        w_cause   = '0;
        w_epc     = epc_cur;
        w_tval    = '0;
        w_is_mret = 1'b0;
        if (w_int_event) begin
            w_cause = CAUSE_MEI;
            w_epc   = epc_next;
        end else if (illegal_inst) begin
            w_cause = XLEN'(2);
        end else if (ecall_m) begin
            w_cause = XLEN'(11);
        end else if (l_access_fault) begin
            w_cause = XLEN'(5);
            w_tval  = bad_addr;
        end else if (s_access_fault) begin
            w_cause = XLEN'(7);
            w_tval  = bad_addr;
        end else begin
            w_is_mret = 1'b1;
        end
    end

    // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M.
    always_comb begin
        w_mstatus_trap        = mstatus_in;
        w_mstatus_trap[7]     = mstatus_in[3];
        w_mstatus_trap[3]     = 1'b0;
        w_mstatus_trap[12:11] = 2'b11;
    end

    // Trap return: MIE <= MPIE, MPIE <= 1.
    always_comb begin
        w_mstatus_mret    = mstatus_in;
        w_mstatus_mret[3] = mstatus_in[7];
        w_mstatus_mret[7] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cause   <= '0;
            r_epc     <= '0;
            r_tval    <= '0;
            r_is_mret <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && w_event) begin
                r_cause   <= w_cause;
                r_epc     <= w_epc;
                r_tval    <= w_tval;
                r_is_mret <= w_is_mret;
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        csr_we         = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        flush_all      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (r_state)
            S_IDLE: begin
                flush_all = w_event;
                if (w_event) begin
                    // Instruction write on this cycle is dropped.
                    w_state_next = w_is_mret ? S_M_MSTATUS : S_W_MEPC;
                end else if (inst_csr_we) begin
                    csr_we    = 1'b1;
                    csr_waddr = inst_csr_addr;
                    csr_wdata = inst_csr_wdata;
                end
            end
            S_W_MEPC: begin
                csr_we       = 1'b1;
                csr_waddr    = A_MEPC;
                csr_wdata    = r_epc;
                w_state_next = S_W_MCAUSE;
            end
            S_W_MCAUSE: begin
                csr_we       = 1'b1;
                csr_waddr    = A_MCAUSE;
                csr_wdata    = r_cause;
                w_state_next = S_W_MTVAL;
            end
            S_W_MTVAL: begin
                csr_we       = 1'b1;
                csr_waddr    = A_MTVAL;
                csr_wdata    = r_tval;
                w_state_next = S_W_MSTATUS;
            end
            S_W_MSTATUS: begin
                csr_we       = 1'b1;
                csr_waddr    = A_MSTATUS;
                csr_wdata    = w_mstatus_trap;
                w_state_next = S_REDIRECT;
            end
            S_M_MSTATUS: begin
                csr_we       = 1'b1;
                csr_waddr    = A_MSTATUS;
                csr_wdata    = w_mstatus_mret;
                w_state_next = S_REDIRECT;
            end
            S_REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = r_is_mret ? mepc_in : {mtvec_in[XLEN-1:2], 2'b00};
                w_state_next   = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign busy           = (r_state != S_IDLE);
    assign inst_csr_stall = busy;

endmodule

// File: tb/tb_trap_sequencer.sv
// ---------------------------------------------------------------------------
// tb_trap_sequencer
//   Cycle-by-cycle vector table for the trap, pass-through, mret and
//   access-fault sequences, plus hand-written sequences for simultaneous
//   interrupt/ecall priority and reset in the middle of a trap.
// ---------------------------------------------------------------------------
module tb_trap_sequencer;

    localparam int XLEN   = 32;
    localparam int CSR_AW = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              interrupt, illegal_inst, ecall_m;
    logic              l_access_fault, s_access_fault, mret;
    logic [XLEN-1:0]   epc_cur, epc_next, bad_addr;
    logic              inst_csr_we;
    logic [CSR_AW-1:0] inst_csr_addr;
    logic [XLEN-1:0]   inst_csr_wdata;
    logic [XLEN-1:0]   mstatus_in, mtvec_in, mepc_in;
    logic              csr_we;
    logic [CSR_AW-1:0] csr_waddr;
    logic [XLEN-1:0]   csr_wdata;
    logic              inst_csr_stall, flush_all, redirect_valid, busy;
    logic [XLEN-1:0]   redirect_pc;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    trap_sequencer #(.XLEN(XLEN), .CSR_AW(CSR_AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .interrupt      (interrupt),
        .illegal_inst   (illegal_inst),
        .ecall_m        (ecall_m),
        .l_access_fault (l_access_fault),
        .s_access_fault (s_access_fault),
        .mret           (mret),
        .epc_cur        (epc_cur),
        .epc_next       (epc_next),
        .bad_addr       (bad_addr),
        .inst_csr_we    (inst_csr_we),
        .inst_csr_addr  (inst_csr_addr),
        .inst_csr_wdata (inst_csr_wdata),
        .mstatus_in     (mstatus_in),
        .mtvec_in       (mtvec_in),
        .mepc_in        (mepc_in),
        .csr_we         (csr_we),
        .csr_waddr      (csr_waddr),
        .csr_wdata      (csr_wdata),
        .inst_csr_stall (inst_csr_stall),
        .flush_all      (flush_all),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
    );

    // ev bits: {interrupt, illegal, ecall, l_fault, s_fault, mret}
    typedef struct {
        logic        rst;
        logic [5:0]  ev;
        logic [31:0] mst;
        logic        iwe;
        logic [11:0] iaddr;
        logic [31:0] iwdata;
        logic        e_we;
        logic [11:0] e_waddr;
        logic [31:0] e_wdata;
        logic        e_flush;
        logic        e_busy;
        logic        e_rv;
        logic [31:0] e_rpc;
    } vec_t;

    localparam logic [5:0] EV_NONE = 6'b000000;
    localparam logic [5:0] EV_INT  = 6'b100000;
    localparam logic [5:0] EV_ILL  = 6'b010000;
    localparam logic [5:0] EV_ECL  = 6'b001000;
    localparam logic [5:0] EV_LF   = 6'b000100;
    localparam logic [5:0] EV_SF   = 6'b000010;
    localparam logic [5:0] EV_MRET = 6'b000001;

    vec_t vecs[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic drive(input logic r, input logic [5:0] ev, input logic [31:0] mst,
                         input logic iwe, input logic [11:0] ia, input logic [31:0] iwd);
        @(posedge clk);
        #1;
        rst            = r;
        {interrupt, illegal_inst, ecall_m, l_access_fault, s_access_fault, mret} = ev;
        mstatus_in     = mst;
        inst_csr_we    = iwe;
        inst_csr_addr  = ia;
        inst_csr_wdata = iwd;
    endtask

    // Outputs sampled on the falling edge, mid-cycle.
    task automatic expect_out(input string tag, input logic we, input logic [11:0] wa,
                              input logic [31:0] wd, input logic fl, input logic bz,
                              input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        chk({tag, " csr_we"}, 32'(csr_we), 32'(we));
        if (we) begin
            chk({tag, " csr_waddr"}, 32'(csr_waddr), 32'(wa));
            chk({tag, " csr_wdata"}, csr_wdata, wd);
        end
        chk({tag, " flush_all"}, 32'(flush_all), 32'(fl));
        chk({tag, " busy"}, 32'(busy), 32'(bz));
        chk({tag, " stall"}, 32'(inst_csr_stall), 32'(bz));
        chk({tag, " redirect_valid"}, 32'(redirect_valid), 32'(rv));
        chk({tag, " redirect_pc"}, redirect_pc, rpc);
    endtask

    initial begin
        // Test 1: illegal instruction, full trap sequence; concurrent inst write dropped.
        vecs[0]  = '{1'b1, EV_NONE, 32'h0,  1'b0, 12'h0,   32'h0,    1'b0, 12'h0,   32'h0,     1'b0, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, EV_NONE, 32'h8,  1'b0, 12'h0,   32'h0,    1'b0, 12'h0,   32'h0,     1'b0, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, EV_ILL,  32'h8,  1'b1, 12'h305, 32'h55,   1'b0, 12'h0,   32'h0,     1'b1, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, EV_NONE, 32'h8,  1'b0, 12'h0,   32'h0,    1'b1, 12'h341, 32'h100,   1'b1, 1'b1, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, EV_NONE, 32'h8,  1'b0, 12'h0,   32'h0,    1'b1, 12'h342, 32'h2,     1'b1, 1'b1, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, EV_NONE, 32'h8,  1'b0, 12'h0,   32'h0,    1'b1, 12'h343, 32'h0,     1'b1, 1'b1, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, EV_NONE, 32'h8,  1'b0, 12'h0,   32'h0,    1'b1, 12'h300, 32'h1880,  1'b1, 1'b1, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, EV_NONE, 32'h8,  1'b0, 12'h0,   32'h0,    1'b0, 12'h0,   32'h0,     1'b1, 1'b1, 1'b1, 32'h200};
        vecs[8]  = '{1'b0, EV_NONE, 32'h8,  1'b0, 12'h0,   32'h0,    1'b0, 12'h0,   32'h0,     1'b0, 1'b0, 1'b0, 32'h0};
        // Test 3: masked interrupt, instruction CSR write passes through.
        vecs[9]  = '{1'b0, EV_INT,  32'h0,  1'b1, 12'h305, 32'h1234, 1'b1, 12'h305, 32'h1234,  1'b0, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b0, EV_NONE, 32'h0,  1'b0, 12'h0,   32'h0,    1'b0, 12'h0,   32'h0,     1'b0, 1'b0, 1'b0, 32'h0};
        // Test 4: mret with MPIE=1.
        vecs[11] = '{1'b0, EV_MRET, 32'h80, 1'b0, 12'h0,   32'h0,    1'b0, 12'h0,   32'h0,     1'b1, 1'b0, 1'b0, 32'h0};
        vecs[12] = '{1'b0, EV_NONE, 32'h80, 1'b0, 12'h0,   32'h0,    1'b1, 12'h300, 32'h88,    1'b1, 1'b1, 1'b0, 32'h0};
        vecs[13] = '{1'b0, EV_NONE, 32'h88, 1'b0, 12'h0,   32'h0,    1'b0, 12'h0,   32'h0,     1'b1, 1'b1, 1'b1, 32'h80};
        vecs[14] = '{1'b0, EV_NONE, 32'h88, 1'b0, 12'h0,   32'h0,    1'b0, 12'h0,   32'h0,     1'b0, 1'b0, 1'b0, 32'h0};
        // Test 5: load fault; store fault and an inst write arrive while busy.
        vecs[15] = '{1'b0, EV_LF,   32'h0,  1'b0, 12'h0,   32'h0,    1'b0, 12'h0,   32'h0,     1'b1, 1'b0, 1'b0, 32'h0};
        vecs[16] = '{1'b0, EV_NONE, 32'h0,  1'b0, 12'h0,   32'h0,    1'b1, 12'h341, 32'h100,   1'b1, 1'b1, 1'b0, 32'h0};
        vecs[17] = '{1'b0, EV_SF,   32'h0,  1'b1, 12'h305, 32'h77,   1'b1, 12'h342, 32'h5,     1'b1, 1'b1, 1'b0, 32'h0};
        vecs[18] = '{1'b0, EV_NONE, 32'h0,  1'b0, 12'h0,   32'h0,    1'b1, 12'h343, 32'hDEAD,  1'b1, 1'b1, 1'b0, 32'h0};
        vecs[19] = '{1'b0, EV_NONE, 32'h0,  1'b0, 12'h0,   32'h0,    1'b1, 12'h300, 32'h1800,  1'b1, 1'b1, 1'b0, 32'h0};
        vecs[20] = '{1'b0, EV_NONE, 32'h0,  1'b0, 12'h0,   32'h0,    1'b0, 12'h0,   32'h0,     1'b1, 1'b1, 1'b1, 32'h200};
        vecs[21] = '{1'b0, EV_NONE, 32'h0,  1'b0, 12'h0,   32'h0,    1'b0, 12'h0,   32'h0,     1'b0, 1'b0, 1'b0, 32'h0};

        rst = 1'b1;
        {interrupt, illegal_inst, ecall_m, l_access_fault, s_access_fault, mret} = '0;
        epc_cur = 32'h100; epc_next = 32'h48; bad_addr = 32'hDEAD;
        mtvec_in = 32'h201; mepc_in = 32'h80; mstatus_in = '0;
        inst_csr_we = 1'b0; inst_csr_addr = '0; inst_csr_wdata = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].rst, vecs[i].ev, vecs[i].mst, vecs[i].iwe, vecs[i].iaddr, vecs[i].iwdata);
            expect_out($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_waddr, vecs[i].e_wdata,
                       vecs[i].e_flush, vecs[i].e_busy, vecs[i].e_rv, vecs[i].e_rpc);
            $display("vec %0d: we=%0b waddr=%03h wdata=%08h flush=%0b busy=%0b rv=%0b rpc=%08h",
                     i, csr_we, csr_waddr, csr_wdata, flush_all, busy, redirect_valid, redirect_pc);
        end

        // Test 2: interrupt and ecall together with MIE=1; interrupt wins.
        drive(1'b0, EV_INT | EV_ECL, 32'h8, 1'b0, 12'h0, 32'h0);
        expect_out("t2 detect", 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b0, EV_NONE, 32'h8, 1'b0, 12'h0, 32'h0);
        expect_out("t2 mepc", 1'b1, 12'h341, 32'h48, 1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b0, EV_NONE, 32'h8, 1'b0, 12'h0, 32'h0);
        expect_out("t2 mcause", 1'b1, 12'h342, 32'h8000000B, 1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b0, EV_NONE, 32'h8, 1'b0, 12'h0, 32'h0);
        expect_out("t2 mtval", 1'b1, 12'h343, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b0, EV_NONE, 32'h8, 1'b0, 12'h0, 32'h0);
        expect_out("t2 mstatus", 1'b1, 12'h300, 32'h1880, 1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b0, EV_NONE, 32'h8, 1'b0, 12'h0, 32'h0);
        expect_out("t2 redirect", 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h200);
        drive(1'b0, EV_NONE, 32'h8, 1'b0, 12'h0, 32'h0);
        expect_out("t2 idle", 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        $display("t2: interrupt+ecall sequence done");

        // Test 6: reset while in W_MTVAL aborts without a redirect.
        drive(1'b0, EV_LF, 32'h0, 1'b0, 12'h0, 32'h0);
        expect_out("t6 detect", 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b0, EV_NONE, 32'h0, 1'b0, 12'h0, 32'h0);
        expect_out("t6 mepc", 1'b1, 12'h341, 32'h100, 1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b0, EV_NONE, 32'h0, 1'b0, 12'h0, 32'h0);
        expect_out("t6 mcause", 1'b1, 12'h342, 32'h5, 1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b1, EV_NONE, 32'h0, 1'b0, 12'h0, 32'h0);
        expect_out("t6 mtval", 1'b1, 12'h343, 32'hDEAD, 1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b0, EV_NONE, 32'h0, 1'b0, 12'h0, 32'h0);
        expect_out("t6 after rst", 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, EV_NONE, 32'h0, 1'b0, 12'h0, 32'h0);
        expect_out("t6 no redirect", 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        $display("t6: reset-abort sequence done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
